// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if
//   Operand/result handshake bundle for pipelined_adder.
//   Input side  : in_valid/in_ready handshake carrying A, B, Cin, Sub.
//   Output side : out_valid/out_ready handshake carrying Sum, Cout, Ovf.
//   master : the producer/consumer that surrounds the adder.
//   slave  : the adder itself.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Carry-pipelined add/subtract. Each stage adds one STAGE_W-bit slice using
//   the carry registered by the previous stage; operands ride along with the
//   beat and finished sum slices are carried forward, so a full result appears
//   NSTAGES cycles after acceptance. Stalls only when the result is not taken.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : pipelined_adder_if.slave (in_valid/in_ready, A, B, Cin, Sub,
//             out_valid/out_ready, Sum, Cout, Ovf)
//   The interface WIDTH must match this module's WIDTH.
module pipelined_adder #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);
    localparam int NSTAGES = WIDTH / STAGE_W;
    localparam int MSB     = WIDTH - 1;

    generate
        if ((WIDTH % STAGE_W) != 0) begin : g_bad_width
            $error("pipelined_adder: WIDTH must be a multiple of STAGE_W");
        end
    endgenerate

    // stage registers
    logic             v_q [NSTAGES];
    logic             c_q [NSTAGES];
    logic [WIDTH-1:0] a_q [NSTAGES];
    logic [WIDTH-1:0] b_q [NSTAGES];   // effective B (already inverted for subtract)
    logic [WIDTH-1:0] s_q [NSTAGES];
    logic             ovf_q;

    // per-stage inputs: stage 0 takes the port, stage k takes stage k-1
    logic             pv [NSTAGES];
    logic             pc [NSTAGES];
    logic [WIDTH-1:0] pa [NSTAGES];
    logic [WIDTH-1:0] pb [NSTAGES];
    logic [WIDTH-1:0] ps [NSTAGES];

    logic             c_d [NSTAGES];
    logic [WIDTH-1:0] s_d [NSTAGES];
    logic             ovf_d;
    logic [STAGE_W:0] slice;

    logic             stall;
    logic             adv;

    assign stall = v_q[NSTAGES-1] & ~bus.out_ready;
    assign adv   = ~stall;

    always_comb begin
        pv[0] = bus.in_valid;
        pa[0] = bus.A;
        pb[0] = bus.Sub ? ~bus.B : bus.B;
        pc[0] = bus.Sub ? 1'b1 : bus.Cin;
        ps[0] = '0;
        for (int k = 1; k < NSTAGES; k++) begin
            pv[k] = v_q[k-1];
            pa[k] = a_q[k-1];
            pb[k] = b_q[k-1];
            pc[k] = c_q[k-1];
            ps[k] = s_q[k-1];
        end
    end

    always_comb begin
        slice = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            slice = {1'b0, pa[k][k*STAGE_W +: STAGE_W]}
                  + {1'b0, pb[k][k*STAGE_W +: STAGE_W]}
                  + {{STAGE_W{1'b0}}, pc[k]};
            s_d[k] = ps[k];
            s_d[k][k*STAGE_W +: STAGE_W] = slice[STAGE_W-1:0];
            c_d[k] = slice[STAGE_W];
        end
        // overflow is resolved in the last stage, where the MSB slice is added
        ovf_d = (pa[NSTAGES-1][MSB] == pb[NSTAGES-1][MSB]) &&
                (s_d[NSTAGES-1][MSB] != pa[NSTAGES-1][MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSTAGES; k++) begin
                v_q[k] <= pv[k];
                c_q[k] <= c_d[k];
                a_q[k] <= pa[k];
                b_q[k] <= pb[k];
                s_q[k] <= s_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = v_q[NSTAGES-1];
    assign bus.Sum       = s_q[NSTAGES-1];
    assign bus.Cout      = c_q[NSTAGES-1];
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Directed vectors with hand-computed results, backpressure, reset
//   mid-flight and a random stream checked against a flat add/subtract model.
module tb_pipelined_adder;
    localparam int WIDTH   = 16;
    localparam int STAGE_W = 4;
    localparam int NST     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGE_W(STAGE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q [$];
    int n_acc = 0;
    int n_out = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // {Ovf, Cout, Sum}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] r;
        logic        ov;
        be = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {16'b0, (sub ? 1'b1 : cin)};
        ov = (a[15] == be[15]) && (r[15] != a[15]);
        return {ov, r};
    endfunction

    // scoreboard: sampled on the falling edge, where the handshakes are stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
                else chk("result", 32'({bus.Ovf, bus.Cout, bus.Sum}), 32'(exp_q.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.Cin, bus.Sub));
                n_acc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.Sub      = sub;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                          input logic [15:0] es, input logic ec, input logic eo, input string tag);
        int lat;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        drive(a, b, cin, sub);
        step();
        bus.in_valid = 1'b0;
        wait_out(1, lat);
        chk({tag, "_lat"}, 32'(lat), NST);
        chk({tag, "_sum"}, 32'(bus.Sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.Cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.Ovf), 32'(eo));
        step();
    endtask

    initial begin
        int lat;
        int w;
        int n0;
        int acc0;
        int target;
        logic [17:0] cap;
        bit rnd_done;

        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.Sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.Sum), 32'd0);
        chk("rst_cout", 32'(bus.Cout), 32'd0);
        chk("rst_ovf", 32'(bus.Ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        single(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "zero");

        // back-to-back beats
        drive(16'h5555, 16'h5555, 1'b1, 1'b0);
        step();
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        wait_out(2, lat);
        chk("b2b_lat", 32'(lat), NST);
        chk("b2b0_sum", 32'(bus.Sum), 32'hAAAB);
        chk("b2b0_cout", 32'(bus.Cout), 32'd0);
        chk("b2b0_ovf", 32'(bus.Ovf), 32'd1);
        step();
        chk("b2b1_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b1_sum", 32'(bus.Sum), 32'hFFFF);
        chk("b2b1_cout", 32'(bus.Cout), 32'd1);
        chk("b2b1_ovf", 32'(bus.Ovf), 32'd0);
        step();

        single(16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub");
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf");

        // backpressure: 8 beats, stall 3 cycles at the first result
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bit acc;
                    int g;
                    drive(16'(16'h1357 * (i + 1)), 16'(16'h2468 ^ (i * 16'h0F0F)), 1'(i), 1'(i >> 1));
                    acc = 1'b0;
                    g   = 0;
                    while (!acc && g < 50) begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        step();
                        g++;
                    end
                end
                bus.in_valid = 1'b0;
            end
            begin
                w = 0;
                while (!bus.out_valid && w < 40) begin
                    step();
                    w++;
                end
                chk("bp_seen", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b0;
                cap = {bus.Ovf, bus.Cout, bus.Sum};
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
                    chk("bp_frozen", 32'({bus.Ovf, bus.Cout, bus.Sum}), 32'(cap));
                end
                step();
                bus.out_ready = 1'b1;
            end
        join
        w = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && w < 100) begin
            step();
            w++;
        end
        chk("bp_lost", 32'(exp_q.size()), 32'd0);
        chk("bp_count", 32'(n_out - n0), 32'd8);

        // reset with 3 beats in flight, the oldest already presenting
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        drive(16'h3333, 16'h4444, 1'b1, 1'b0);
        step();
        drive(16'h5555, 16'h0001, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_sum", 32'(bus.Sum), 32'd0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("no_stale", 32'(bus.out_valid), 32'd0);
        end
        single(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "post_rst");

        // random stream
        n0       = n_out;
        acc0     = n_acc;
        target   = n_acc + 1000;
        rnd_done = 1'b0;
        fork
            begin
                int cyc = 0;
                while (n_acc < target && cyc < 20000) begin
                    if ($urandom_range(3) != 0)
                        drive(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
                    else
                        bus.in_valid = 1'b0;
                    step();
                    cyc++;
                end
                bus.in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = ($urandom_range(2) != 0);
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        w = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && w < 100) begin
            step();
            w++;
        end
        chk("rnd_acc", 32'(n_acc - acc0), 32'd1000);
        chk("rnd_lost", 32'(exp_q.size()), 32'd0);
        chk("rnd_count", 32'(n_out - n0), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGE_W, default 4, giving the bits added per pipeline stage.
REQ-003 NSTAGES SHALL equal WIDTH/STAGE_W, and a WIDTH not divisible by STAGE_W SHALL cause an elaboration error.
REQ-004 clk  input  1  is the single clock, and all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  is the reset, which SHALL be asynchronous and active-low.
REQ-006 in_valid  input  1  SHALL flag that the operand beat is valid.
REQ-007 in_ready  output  1  SHALL flag that the block accepts a beat this cycle.
REQ-008 A  input  WIDTH  SHALL carry operand A.
REQ-009 B  input  WIDTH  SHALL carry operand B.
REQ-010 Cin  input  1  SHALL carry the carry-in, which is ignored when Sub=1.
REQ-011 Sub  input  1  SHALL select the operation: 0 = add, 1 = subtract.
REQ-012 out_valid  output  1  SHALL flag that the result beat is valid.
REQ-013 out_ready  input  1  SHALL flag that the downstream accepts the result.
REQ-014 Sum  output  WIDTH  SHALL carry the result.
REQ-015 Cout  output  1  SHALL carry the carry out of the MSB; for subtract, 1 means no borrow.
REQ-016 Ovf  output  1  SHALL flag two's-complement signed overflow.

Function
REQ-017 Add SHALL compute {Cout,Sum} = A + B + Cin; subtract SHALL compute {Cout,Sum} = A + ~B + 1.
REQ-018 Ovf SHALL be 1 exactly when A[MSB] equals Beff[MSB] and Sum[MSB] differs from A[MSB], where Beff is B for add and ~B for subtract.
REQ-019 Stage k (0..NSTAGES-1) SHALL add bit slice [k*STAGE_W +: STAGE_W] using the registered carry from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-020 Operand slices not yet consumed SHALL be delayed in registers alongside their beat, and finished sum slices SHALL be carried forward so each beat's full Sum is aligned at the output.
REQ-021 Each stage SHALL hold one valid bit, and a beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-022 Latency SHALL be exactly NSTAGES cycles from acceptance to out_valid=1 when out_ready is held at 1.
REQ-023 Throughput SHALL be one beat per cycle when out_ready=1.
REQ-024 stall SHALL equal out_valid AND NOT out_ready.
REQ-025 in_ready SHALL equal NOT stall.
REQ-026 During stall, every stage register, including the valid bits, SHALL hold its value.
REQ-027 Sum, Cout, Ovf and out_valid SHALL be registered outputs and SHALL remain stable while stalled.
REQ-028 Bubbles, meaning stages with valid=0, SHALL advance like data; no bubble collapsing is required.
REQ-029 A beat SHALL complete when out_valid and out_ready are both 1; a new beat MAY arrive in the same cycle.
REQ-030 When in_valid=0 on an advancing cycle, a bubble SHALL enter stage 0, and data registers of invalid stages are don't-care.
REQ-031 Beats SHALL emerge in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-032 When STAGE_W equals WIDTH, the block SHALL degenerate to a single registered stage with latency 1.

Reset
REQ-033 While rst_n=0, all stage valid bits SHALL be 0, out_valid SHALL be 0, and Sum, Cout and Ovf SHALL be 0.
REQ-034 Reset assertion mid-operation SHALL discard all in-flight beats immediately, without waiting for clk.
REQ-035 After rst_n deasserts, in_ready SHALL be 1, and the first accepted beat SHALL appear after NSTAGES cycles.

Verification (WIDTH=16, STAGE_W=4, NSTAGES=4)
REQ-036 The bench SHALL check: A=0x0000, B=0x0000, Cin=0, Sub=0 -> 4 cycles later Sum=0x0000, Cout=0, Ovf=0.
REQ-037 The bench SHALL check: back-to-back A=0x5555+0x5555 Cin=1, then A=0xFFFF+0xFFFF Cin=1 -> consecutive cycles Sum=0xAAAB, Cout=0, Ovf=1, then Sum=0xFFFF, Cout=1, Ovf=0.
REQ-038 The bench SHALL check: Sub=1, A=0x0001, B=0x0002, Cin=1 -> Sum=0xFFFF, Cout=0, Ovf=0; then A=0x7FFF+0x0001, Sub=0 -> Sum=0x8000, Cout=0, Ovf=1.
REQ-039 The bench SHALL check backpressure: it streams 8 beats and holds out_ready=0 for 3 cycles once out_valid=1 -> in_ready=0 and outputs frozen for 3 cycles, then all 8 results arrive in order, none lost or duplicated.
REQ-040 The bench SHALL check reset mid-flight: it asserts rst_n=0 with 3 beats in flight -> out_valid=0 immediately; after release, no stale beat emerges and the next beat has latency 4.
REQ-041 The bench SHALL run a randomised 1000-beat stream with random in_valid/out_ready -> every result matches a reference model of REQ-017 and REQ-018 in order.
